// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: req/gnt/rvalid data-memory handshake, store lane steering, load extraction.
// Optional LSU_MISALIGN_TRAP_EN: reject misaligned accesses instead of issuing them lane-aligned.
module lsu_mem_stage #(
  parameter int unsigned W           = 32,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic         ld_en_i,
  input  logic         st_en_i,
  input  logic [2:0]   funct3_i,
  input  logic [W-1:0] addr_i,
  input  logic [W-1:0] st_data_i,
  output logic         dmem_req_o,
  output logic         dmem_we_o,
  output logic [W-1:0] dmem_addr_o,
  output logic [3:0]   dmem_be_o,
  output logic [W-1:0] dmem_wdata_o,
  input  logic         dmem_gnt_i,
  input  logic         dmem_rvalid_i,
  input  logic [W-1:0] dmem_rdata_i,
  output logic [W-1:0] ld_data_o,
  output logic         stall_o,
  output logic         done_o,
  output logic         bus_err_o,
  output logic         misalign_o
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t             state;
  size_t              size_q;
  logic [1:0]         lane_q;
  logic               sgn_q;
  logic [CNT_W-1:0]   cnt;

  logic               acc;
  logic               trap;
  size_t              size;
  logic [1:0]         lane;
  logic [3:0]         be;
  logic [W-1:0]       wdata;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [W-1:0]       ld_ext;

  assign acc = valid_i & (ld_en_i | st_en_i);

  // Access size: loads ignore funct3[2] (sign bit), stores decode all three bits.
  always_comb begin
    size = SZ_W;
    if (ld_en_i) begin
      if (funct3_i[1:0] == 2'b00)      size = SZ_B;
      else if (funct3_i[1:0] == 2'b01) size = SZ_H;
    end else begin
      if (funct3_i == 3'b000)          size = SZ_B;
      else if (funct3_i == 3'b001)     size = SZ_H;
    end
  end

  // Lane is forced naturally aligned for halves and words.
  always_comb begin
    lane  = addr_i[1:0];
    be    = 4'hF;
    wdata = st_data_i;
    case (size)
      SZ_B: begin
        be    = 4'(4'b0001 << lane);
        wdata = {4{st_data_i[7:0]}};
      end
      SZ_H: begin
        lane  = addr_i[1:0] & 2'b10;
        be    = 4'(4'b0011 << lane);
        wdata = {2{st_data_i[15:0]}};
      end
      default: lane = 2'b00;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata_i[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (size_q)
      SZ_B:    ld_ext = {{(W-8){sgn_q & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_ext = {{(W-16){sgn_q & ld_half[15]}}, ld_half};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis;
  assign mis        = ((size == SZ_H) && addr_i[0]) || ((size == SZ_W) && (addr_i[1:0] != 2'b00));
  assign trap       = acc & mis;
  assign misalign_o = ~rst_i & (state == IDLE) & trap;
`else
  assign trap       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign stall_o = ~rst_i & (((state == IDLE) & acc & ~trap) | (state == REQ) | (state == WAIT));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      size_q       <= SZ_B;
      lane_q       <= 2'b00;
      sgn_q        <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      ld_data_o    <= '0;
      done_o       <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      bus_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (acc && !trap) begin
            size_q       <= size;
            lane_q       <= lane;
            sgn_q        <= ~funct3_i[2];
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= ~ld_en_i;
            dmem_addr_o  <= {addr_i[W-1:2], 2'b00};
            dmem_be_o    <= be;
            dmem_wdata_o <= wdata;
            state        <= REQ;
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            cnt        <= '0;
            if (dmem_we_o) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            ld_data_o <= ld_ext;
            done_o    <= 1'b1;
            state     <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            ld_data_o <= '0;
            done_o    <= 1'b1;
            bus_err_o <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage (stores, loads, delayed handshake, timeout, reset).
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ld_en;
  logic        st_en;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] ld_data;
  logic        stall;
  logic        done;
  logic        bus_err;
  logic        misalign;

  int checks;
  int failures;
  logic [31:0] last_ld;

  lsu_mem_stage #(.W(32), .TIMEOUT_CYC(15)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .valid_i       (valid),
    .ld_en_i       (ld_en),
    .st_en_i       (st_en),
    .funct3_i      (funct3),
    .addr_i        (addr),
    .st_data_i     (st_data),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_addr_o   (dmem_addr),
    .dmem_be_o     (dmem_be),
    .dmem_wdata_o  (dmem_wdata),
    .dmem_gnt_i    (dmem_gnt),
    .dmem_rvalid_i (dmem_rvalid),
    .dmem_rdata_i  (dmem_rdata),
    .ld_data_o     (ld_data),
    .stall_o       (stall),
    .done_o        (done),
    .bus_err_o     (bus_err),
    .misalign_o    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1; ld_en = ld; st_en = st; funct3 = f3; addr = a; st_data = d;
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; ld_en = 1'b0; st_en = 1'b0;
    #1;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    issue(1'b0, 1'b1, f3, a, d);
    check({tag, ".stall_idle"}, stall, 1);
    check({tag, ".req_idle"}, dmem_req, 0);
    step();
    check({tag, ".req"}, dmem_req, 1);
    check({tag, ".we"}, dmem_we, 1);
    check({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
    check({tag, ".be"}, dmem_be, exp_be);
    check({tag, ".wdata"}, dmem_wdata, exp_wd);
    check({tag, ".stall_req"}, stall, 1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #1;
    check({tag, ".done"}, done, 1);
    check({tag, ".stall_done"}, stall, 0);
    check({tag, ".ld_hold"}, ld_data, last_ld);
    step();
    idle();
    check({tag, ".no_reissue"}, dmem_req, 0);
    check({tag, ".done_pulse"}, done, 0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'h0);
    check({tag, ".stall_idle"}, stall, 1);
    step();
    check({tag, ".req"}, dmem_req, 1);
    check({tag, ".we"}, dmem_we, 0);
    check({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #1;
    check({tag, ".req_wait"}, dmem_req, 0);
    check({tag, ".stall_wait"}, stall, 1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = rd;
    step();
    dmem_rvalid = 1'b0;
    #1;
    check({tag, ".done"}, done, 1);
    check({tag, ".stall_done"}, stall, 0);
    check({tag, ".bus_err"}, bus_err, 0);
    check({tag, ".data"}, ld_data, exp);
    last_ld = exp;
    idle();
    step();
  endtask

  initial begin
    checks = 0; failures = 0; last_ld = 32'h0;
    rst = 1'b1; valid = 1'b0; ld_en = 1'b0; st_en = 1'b0; funct3 = 3'b000;
    addr = 32'h0; st_data = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    step();
    step();
    check("rst.req", dmem_req, 0);
    check("rst.stall", stall, 0);
    check("rst.done", done, 0);
    check("rst.ld_data", ld_data, 0);
    check("rst.be", dmem_be, 0);
    check("rst.misalign", misalign, 0);
    rst = 1'b0;
    step();

    do_store("sw", 3'b010, 32'h100, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);

    do_load("lb",  3'b000, 32'h102, 32'h80FF7F01, 32'hFFFFFFFF);
    do_load("lhu", 3'b101, 32'h102, 32'h80FF7F01, 32'h000080FF);
    do_load("lh",  3'b001, 32'h100, 32'h80FF7F01, 32'h00007F01);
    do_load("lbu", 3'b100, 32'h103, 32'h80FF7F01, 32'h00000080);
    do_load("lb1", 3'b000, 32'h101, 32'h80FF7F01, 32'h0000007F);

    do_store("sb",  3'b000, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    do_store("sh",  3'b001, 32'h102, 32'h00001234, 4'b1100, 32'h12341234);
    do_store("sb0", 3'b000, 32'h100, 32'hFFFFFF7C, 4'b0001, 32'h7C7C7C7C);

    // Grant delayed three cycles, early rvalid ignored, data two cycles after grant
    issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("dly.req", dmem_req, 1);
      check("dly.addr", dmem_addr, 32'h200);
      check("dly.stall", stall, 1);
      dmem_rvalid = 1'b0;
      step();
    end
    check("dly.req4", dmem_req, 1);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #1;
    check("dly.stall_w1", stall, 1);
    check("dly.done_w1", done, 0);
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFEF00D;
    #1;
    check("dly.stall_w2", stall, 1);
    step();
    dmem_rvalid = 1'b0;
    #1;
    check("dly.done", done, 1);
    check("dly.data", ld_data, 32'hCAFEF00D);
    idle();
    step();

    // No rvalid: bus error after 15 WAIT cycles
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    step();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("tmo.stall", stall, 1);
      check("tmo.err_early", bus_err, 0);
      step();
    end
    #1;
    check("tmo.bus_err", bus_err, 1);
    check("tmo.done", done, 1);
    check("tmo.data", ld_data, 0);
    idle();
    step();
    check("tmo.err_pulse", bus_err, 0);

    do_load("lw", 3'b010, 32'h104, 32'h80FF7F01, 32'h80FF7F01);

    // Reset while a request is outstanding
    issue(1'b0, 1'b1, 3'b010, 32'h500, 32'h0);
    step();
    check("rreq.req", dmem_req, 1);
    rst = 1'b1;
    #1;
    check("rreq.req_rst", dmem_req, 0);
    check("rreq.stall_rst", stall, 0);
    idle();
    rst = 1'b0;
    step();

    // Reset mid-WAIT, then a late rvalid
    issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    step();
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("rwait.stall", stall, 0);
    check("rwait.req", dmem_req, 0);
    check("rwait.ld_data", ld_data, 0);
    idle();
    step();
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h12345678;
    step();
    dmem_rvalid = 1'b0;
    #1;
    check("late.ld_data", ld_data, 0);
    check("late.done", done, 0);
    check("late.stall", stall, 0);
    step();
    check("late.done2", done, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    check("mis.flag", misalign, 1);
    check("mis.stall", stall, 0);
    step();
    check("mis.no_req", dmem_req, 0);
    check("mis.flag_idle", misalign, 1);
    idle();
    check("mis.flag_clr", misalign, 0);
    step();
    check("mis.no_req2", dmem_req, 0);
`else
    issue(1'b1, 1'b0, 3'b001, 32'h103, 32'h0);
    check("mis.flag", misalign, 0);
    check("mis.stall", stall, 1);
    step();
    check("mis.req", dmem_req, 1);
    check("mis.addr", dmem_addr, 32'h100);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80FF7F01;
    step();
    dmem_rvalid = 1'b0;
    #1;
    check("mis.done", done, 1);
    check("mis.data", ld_data, 32'hFFFF80FF);
    idle();
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
